// File: rtl/stack_op_seq.sv
// Stack op sequencer: runs PUSH/POP/CALL/RETURN as two byte accesses around sp_in.
// Define STACK_BOUNDS_CHECK_EN to reject overflowing pushes and underflowing pops.
module stack_op_seq #(
   parameter logic [7:0] SP_BASE  = 8'h3E,
   parameter logic [7:0] SP_LIMIT = 8'h7F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_ctl,
   input  logic [15:0] op_data,
   input  logic [7:0]  op_target,
   input  logic [7:0]  sp_in,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        pop_valid,
   output logic [15:0] pop_data,
   output logic        jump_en,
   output logic [7:0]  jump_addr,
   output logic        stack_command,
   output logic [1:0]  stack_ctl,
   output logic        stack_err
);

   typedef enum logic [3:0] {IDLE, CHK, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, UPD, ERR} state_t;
   localparam logic [1:0] OP_POP = 2'd1, OP_CALL = 2'd2, OP_RET = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  ctl_q, ctl_d, stack_ctl_q, stack_ctl_d;
   logic [15:0] data_q, data_d, pop_data_q, pop_data_d;
   logic [7:0]  tgt_q, tgt_d, sp_q, sp_d, lo_q, lo_d;
   logic [7:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, jump_addr_q, jump_addr_d;
   logic        op_ready_q, op_ready_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic        pop_valid_q, pop_valid_d, jump_en_q, jump_en_d, stack_command_q, stack_command_d;
   logic        is_wr, err_hit;

   // PUSH (0) and CALL (2) are the even op codes and both write.
   assign is_wr = ~ctl_q[0];

`ifdef STACK_BOUNDS_CHECK_EN
   logic stack_err_q, stack_err_d;
   assign err_hit   = is_wr ? (sp_q > SP_LIMIT - 8'd1) : (sp_q < SP_BASE + 8'd2);
   assign stack_err = stack_err_q;
`else
   assign err_hit   = 1'b0;
   assign stack_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ctl_d       = ctl_q;
      data_d      = data_q;
      tgt_d       = tgt_q;
      sp_d        = sp_q;
      lo_d        = lo_q;
      stack_ctl_d = stack_ctl_q;
      pop_data_d  = pop_data_q;
      jump_addr_d = jump_addr_q;
      case (state_q)
         IDLE: if (op_valid && op_ready_q) begin
            state_d     = CHK;
            ctl_d       = op_ctl;
            data_d      = op_data;
            tgt_d       = op_target;
            sp_d        = sp_in;
            stack_ctl_d = op_ctl;
         end
         CHK:     state_d = err_hit ? ERR : (is_wr ? WR_LO : RD_LO);
         WR_LO:   state_d = WR_HI;
         WR_HI:   state_d = UPD;
         RD_LO:   state_d = RD_HI;
         RD_HI: begin
            lo_d    = mem_rdata;
            state_d = RD_WAIT;
         end
         RD_WAIT: state_d = UPD;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      op_ready_d      = (state_d == IDLE);
      mem_we_d        = (state_d == WR_LO) || (state_d == WR_HI);
      mem_re_d        = (state_d == RD_LO) || (state_d == RD_HI);
      stack_command_d = (state_d == UPD);
      mem_addr_d      = 8'h00;
      mem_wdata_d     = 8'h00;
      pop_valid_d     = 1'b0;
      jump_en_d       = 1'b0;
      case (state_d)
         WR_LO: begin
            mem_addr_d  = sp_q;
            mem_wdata_d = data_q[7:0];
         end
         WR_HI: begin
            mem_addr_d  = sp_q + 8'd1;
            mem_wdata_d = data_q[15:8];
         end
         RD_LO: mem_addr_d = sp_q - 8'd2;
         RD_HI: mem_addr_d = sp_q - 8'd1;
         UPD: begin
            // Entering UPD from RD_WAIT, mem_rdata carries the high byte.
            if (ctl_q == OP_POP) begin
               pop_valid_d = 1'b1;
               pop_data_d  = {mem_rdata, lo_q};
            end else if (ctl_q == OP_RET) begin
               jump_en_d   = 1'b1;
               jump_addr_d = lo_q;
            end else if (ctl_q == OP_CALL) begin
               jump_en_d   = 1'b1;
               jump_addr_d = tgt_q;
            end
         end
         default: ;
      endcase
`ifdef STACK_BOUNDS_CHECK_EN
      stack_err_d = (state_d == ERR);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         ctl_q           <= 2'd0;
         data_q          <= 16'h0000;
         tgt_q           <= 8'h00;
         sp_q            <= 8'h00;
         lo_q            <= 8'h00;
         stack_ctl_q     <= 2'd0;
         pop_data_q      <= 16'h0000;
         jump_addr_q     <= 8'h00;
         op_ready_q      <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_re_q        <= 1'b0;
         mem_addr_q      <= 8'h00;
         mem_wdata_q     <= 8'h00;
         pop_valid_q     <= 1'b0;
         jump_en_q       <= 1'b0;
         stack_command_q <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
         stack_err_q     <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         ctl_q           <= ctl_d;
         data_q          <= data_d;
         tgt_q           <= tgt_d;
         sp_q            <= sp_d;
         lo_q            <= lo_d;
         stack_ctl_q     <= stack_ctl_d;
         pop_data_q      <= pop_data_d;
         jump_addr_q     <= jump_addr_d;
         op_ready_q      <= op_ready_d;
         mem_we_q        <= mem_we_d;
         mem_re_q        <= mem_re_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         pop_valid_q     <= pop_valid_d;
         jump_en_q       <= jump_en_d;
         stack_command_q <= stack_command_d;
`ifdef STACK_BOUNDS_CHECK_EN
         stack_err_q     <= stack_err_d;
`endif
      end
   end

   assign op_ready      = op_ready_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_we        = mem_we_q;
   assign mem_re        = mem_re_q;
   assign pop_valid     = pop_valid_q;
   assign pop_data      = pop_data_q;
   assign jump_en       = jump_en_q;
   assign jump_addr     = jump_addr_q;
   assign stack_command = stack_command_q;
   assign stack_ctl     = stack_ctl_q;

endmodule

// File: tb/tb_stack_op_seq.sv
// Directed bench for stack_op_seq with a byte-wide data memory model and cycle-exact expectations.
module tb_stack_op_seq;
   logic        clk = 1'b0, reset_n = 1'b0, op_valid = 1'b0;
   logic        op_ready, mem_we, mem_re, pop_valid, jump_en, stack_command, stack_err;
   logic [1:0]  op_ctl = 2'd0, stack_ctl;
   logic [15:0] op_data = 16'h0, pop_data;
   logic [7:0]  op_target = 8'h0, sp_in = 8'h0, mem_addr, mem_wdata, jump_addr;
   logic [7:0]  mem_rdata = 8'h0;
   logic [7:0]  mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = 8'h0, pre_data = 8'h0;
   logic [22:0] obs, exp_v;
   int          errors = 0, checks = 0, cmd_cnt = 0, both_cnt = 0, c0;

   stack_op_seq dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_ctl(op_ctl), .op_data(op_data), .op_target(op_target), .sp_in(sp_in),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .pop_valid(pop_valid), .pop_data(pop_data),
      .jump_en(jump_en), .jump_addr(jump_addr), .stack_command(stack_command),
      .stack_ctl(stack_ctl), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   // Read data is registered: valid the cycle after mem_re.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (stack_command) cmd_cnt <= cmd_cnt + 1;
      if (mem_we && mem_re) both_cnt <= both_cnt + 1;
   end

   assign obs = {op_ready, mem_we, mem_re, mem_addr, mem_wdata, stack_command, pop_valid, jump_en, stack_err};

   function automatic logic [22:0] mk(input logic r, we, re, input logic [7:0] a, w,
                                      input logic c, pv, je, er);
      return {r, we, re, a, w, c, pv, je, er};
   endfunction

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Waits (bounded) for op_ready, then presents one op for a single accept edge.
   task automatic do_op(input logic [1:0] c, input logic [15:0] d, input logic [7:0] t, s);
      int n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         errors++; checks++;
         $display("FAIL accept_timeout op_ready=%b required 1", op_ready);
      end
      op_valid = 1'b1; op_ctl = c; op_data = d; op_target = t; sp_in = s;
      @(posedge clk);
      #1;
      op_valid = 1'b0; op_ctl = ~c; op_data = 16'h5A5A; op_target = 8'hC3; sp_in = 8'hA5;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (obs !== 23'h0 || pop_data !== 16'h0 || stack_ctl !== 2'd0 || jump_addr !== 8'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h/%h/%h/%h required 0", obs, pop_data, stack_ctl, jump_addr);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", op_ready); end
   endtask

   task automatic test_push;
      do_op(2'd0, 16'hBEEF, 8'h00, 8'h3E);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 1, 0, 8'h3E, 8'hEF, 0, 0, 0, 0);
            3:       exp_v = mk(0, 1, 0, 8'h3F, 8'hBE, 0, 0, 0, 0);
            4:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
            5:       exp_v = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL push cyc%0d got %h required %h", k, obs, exp_v); end
      end
      checks++;
      if (mem[8'h3E] !== 8'hEF || mem[8'h3F] !== 8'hBE || stack_ctl !== 2'd0) begin
         errors++;
         $display("FAIL push_mem got %h%h ctl %0d required BEEF ctl 0", mem[8'h3F], mem[8'h3E], stack_ctl);
      end
   endtask

   task automatic test_pop;
      preload(8'h3E, 8'hEF);
      preload(8'h3F, 8'hBE);
      do_op(2'd1, 16'h0000, 8'h00, 8'h40);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 0, 1, 8'h3E, 8'h00, 0, 0, 0, 0);
            3:       exp_v = mk(0, 0, 1, 8'h3F, 8'h00, 0, 0, 0, 0);
            5:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL pop cyc%0d got %h required %h", k, obs, exp_v); end
      end
      checks++;
      if (pop_data !== 16'hBEEF || stack_ctl !== 2'd1) begin
         errors++; $display("FAIL pop_data got %h ctl %0d required BEEF ctl 1", pop_data, stack_ctl);
      end
   endtask

   task automatic test_call;
      do_op(2'd2, 16'h0012, 8'h5A, 8'h40);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 1, 0, 8'h40, 8'h12, 0, 0, 0, 0);
            3:       exp_v = mk(0, 1, 0, 8'h41, 8'h00, 0, 0, 0, 0);
            4:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL call cyc%0d got %h required %h", k, obs, exp_v); end
      end
      checks++;
      if (jump_addr !== 8'h5A) begin errors++; $display("FAIL call_target got %h required 5A", jump_addr); end
   endtask

   task automatic test_return;
      do_op(2'd3, 16'h0000, 8'h00, 8'h42);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 0, 1, 8'h40, 8'h00, 0, 0, 0, 0);
            3:       exp_v = mk(0, 0, 1, 8'h41, 8'h00, 0, 0, 0, 0);
            5:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL return cyc%0d got %h required %h", k, obs, exp_v); end
      end
      checks++;
      if (jump_addr !== 8'h12 || pop_data !== 16'hBEEF) begin
         errors++; $display("FAIL return_jump got %h pop %h required 12 pop BEEF", jump_addr, pop_data);
      end
   endtask

   task automatic test_bounds;
      preload(8'h3C, 8'h34);
      preload(8'h3D, 8'h12);
      #1 c0 = cmd_cnt;
      do_op(2'd1, 16'h0000, 8'h00, 8'h3E);
`ifdef STACK_BOUNDS_CHECK_EN
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp_v = (k == 2) ? mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1) :
                 (k == 3) ? mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0) : 23'h0;
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL underflow cyc%0d got %h required %h", k, obs, exp_v); end
      end
      #1;
      checks++;
      if (cmd_cnt !== c0) begin errors++; $display("FAIL underflow_cmd got %0d required %0d", cmd_cnt, c0); end
      do_op(2'd0, 16'hA55A, 8'h00, 8'h7F);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         exp_v = (k == 2) ? mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1) : 23'h0;
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL overflow cyc%0d got %h required %h", k, obs, exp_v); end
      end
`else
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 0, 1, 8'h3C, 8'h00, 0, 0, 0, 0);
            3:       exp_v = mk(0, 0, 1, 8'h3D, 8'h00, 0, 0, 0, 0);
            5:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL nobounds_pop cyc%0d got %h required %h", k, obs, exp_v); end
      end
      checks++;
      if (pop_data !== 16'h1234) begin errors++; $display("FAIL nobounds_data got %h required 1234", pop_data); end
      do_op(2'd0, 16'hA55A, 8'h00, 8'hFF);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp_v = (k == 2) ? mk(0, 1, 0, 8'hFF, 8'h5A, 0, 0, 0, 0) :
                 (k == 3) ? mk(0, 1, 0, 8'h00, 8'hA5, 0, 0, 0, 0) : 23'h0;
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL wrap cyc%0d got %h required %h", k, obs, exp_v); end
      end
`endif
   endtask

   task automatic test_reset_mid;
      preload(8'h51, 8'h00);
      do_op(2'd0, 16'h1111, 8'h00, 8'h50);
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== mk(0, 1, 0, 8'h51, 8'h11, 0, 0, 0, 0)) begin
         errors++; $display("FAIL mid_wrhi got %h required WR_HI write", obs);
      end
      c0 = cmd_cnt;
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 23'h0) begin errors++; $display("FAIL mid_reset_outputs got %h required 0", obs); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (op_ready !== 1'b1 || cmd_cnt !== c0 || mem[8'h51] !== 8'h00 || mem[8'h50] !== 8'h11) begin
         errors++;
         $display("FAIL mid_recover rdy %b cmds %0d/%0d mem51 %h mem50 %h", op_ready, cmd_cnt, c0, mem[8'h51], mem[8'h50]);
      end
      do_op(2'd0, 16'h2222, 8'h00, 8'h60);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 1, 0, 8'h60, 8'h22, 0, 0, 0, 0);
            3:       exp_v = mk(0, 1, 0, 8'h61, 8'h22, 0, 0, 0, 0);
            4:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL post_reset_push cyc%0d got %h required %h", k, obs, exp_v); end
      end
   endtask

   task automatic test_back_to_back;
      #1 c0 = cmd_cnt;
      do_op(2'd0, 16'hCAFE, 8'h00, 8'h70);
      repeat (4) @(negedge clk);
      do_op(2'd1, 16'h0000, 8'h00, 8'h72);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         case (k)
            2:       exp_v = mk(0, 0, 1, 8'h70, 8'h00, 0, 0, 0, 0);
            3:       exp_v = mk(0, 0, 1, 8'h71, 8'h00, 0, 0, 0, 0);
            5:       exp_v = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
            default: exp_v = 23'h0;
         endcase
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL b2b_pop cyc%0d got %h required %h", k, obs, exp_v); end
      end
      #1;
      checks++;
      if (pop_data !== 16'hCAFE || cmd_cnt !== c0 + 2) begin
         errors++; $display("FAIL b2b_result pop %h cmds %0d required CAFE %0d", pop_data, cmd_cnt, c0 + 2);
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pop();
      test_call();
      test_return();
      test_bounds();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (both_cnt !== 0) begin errors++; $display("FAIL we_re_exclusive got %0d overlaps required 0", both_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
